// File: rtl/mul_unit_pkg.sv
// Shared constants and tag types for the execution-stage multiply unit.
// The issue stage imports the funct codes so its unit select agrees with this block.
package mul_unit_pkg;

  localparam int         MUL_LATENCY = 4;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef struct packed {
    logic [4:0] regdest;
    logic       writereg;
  } wb_tag_t;

  localparam wb_tag_t TAG_NONE = '0;

endpackage

// File: rtl/mul_pipe_tag.sv
// Valid + write-back tag shift register running in lockstep with the multiply datapath.
// The last stage holds its tag while idle so the write-back port keeps its last value.
module mul_pipe_tag
  import mul_unit_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_vld,
  input  logic [4:0]             i_regdest,
  input  logic                   i_writereg,
  output logic [MUL_LATENCY-1:0] o_stage_valid,
  output logic [4:0]             o_regdest,
  output logic                   o_writereg
);

  logic    r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
  wb_tag_t r_tag_p1, r_tag_p2, r_tag_p3, r_tag_p4;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_vld_p4 <= 1'b0;
      r_tag_p1 <= TAG_NONE;
      r_tag_p2 <= TAG_NONE;
      r_tag_p3 <= TAG_NONE;
      r_tag_p4 <= TAG_NONE;
    end else begin
      // S1: empty slots carry a zero tag
      r_vld_p1 <= i_vld;
      r_tag_p1 <= i_vld ? wb_tag_t'({i_regdest, i_writereg}) : TAG_NONE;
      // S2 / S3
      r_vld_p2 <= r_vld_p1;
      r_tag_p2 <= r_tag_p1;
      r_vld_p3 <= r_vld_p2;
      r_tag_p3 <= r_tag_p2;
      // S4: output tag only moves when a real op completes
      r_vld_p4 <= r_vld_p3;
      if (r_vld_p3) r_tag_p4 <= r_tag_p3;
    end
  end

  assign o_stage_valid = {r_vld_p4, r_vld_p3, r_vld_p2, r_vld_p1};
  assign o_regdest     = r_tag_p4.regdest;
  assign o_writereg    = r_tag_p4.writereg;

endmodule

// File: rtl/mul_unit.sv
// Fixed-latency 32x32 MULT/MULTU unit: sign-magnitude capture, 16x16 partial
// products, 64-bit accumulate, then sign fix-up into the HI/LO write-back registers.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iss_mul_oper,
  input  logic [WIDTH-1:0]   iss_ex_rega,
  input  logic [WIDTH-1:0]   iss_ex_regb,
  input  logic               iss_ex_unsig,
  input  logic [4:0]         iss_ex_regdest,
  input  logic               iss_ex_writereg,
  output logic               mul_wb_valid,
  output logic [WIDTH-1:0]   mul_wb_hi,
  output logic [WIDTH-1:0]   mul_wb_lo,
  output logic [4:0]         mul_wb_regdest,
  output logic               mul_wb_writereg,
  output logic [LATENCY-1:0] mul_stage_valid,
  output logic               mul_busy
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  // |v| as an unsigned WIDTH-bit value; the most negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic neg, input logic signed [PW-1:0] s);
    return neg ? -s : s;
  endfunction

  logic [LATENCY-1:0] w_stage_valid;

  logic [WIDTH-1:0] r_a_p1, r_b_p1;
  logic             r_neg_p1;
  logic [WIDTH-1:0] r_ll_p2, r_lh_p2, r_hl_p2, r_hh_p2;
  logic             r_neg_p2;
  logic [PW-1:0]    r_sum_p3;
  logic             r_neg_p3;
  logic [PW-1:0]    r_prod_p4;

  mul_pipe_tag u_tag (
    .clock         (clock),
    .reset         (reset),
    .i_vld         (iss_mul_oper),
    .i_regdest     (iss_ex_regdest),
    .i_writereg    (iss_ex_writereg),
    .o_stage_valid (w_stage_valid),
    .o_regdest     (mul_wb_regdest),
    .o_writereg    (mul_wb_writereg)
  );

  // S1: operand capture, held while no op is issued
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_p1   <= '0;
      r_b_p1   <= '0;
      r_neg_p1 <= 1'b0;
    end else if (iss_mul_oper) begin
      if (iss_ex_unsig) begin
        r_a_p1   <= iss_ex_rega;
        r_b_p1   <= iss_ex_regb;
        r_neg_p1 <= 1'b0;
      end else begin
        r_a_p1   <= magnitude($signed(iss_ex_rega));
        r_b_p1   <= magnitude($signed(iss_ex_regb));
        r_neg_p1 <= iss_ex_rega[WIDTH-1] ^ iss_ex_regb[WIDTH-1];
      end
    end
  end

  // S2: four unsigned half-width partial products
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ll_p2  <= '0;
      r_lh_p2  <= '0;
      r_hl_p2  <= '0;
      r_hh_p2  <= '0;
      r_neg_p2 <= 1'b0;
    end else if (w_stage_valid[0]) begin
      r_ll_p2  <= {{HALF{1'b0}}, r_a_p1[HALF-1:0]}     * {{HALF{1'b0}}, r_b_p1[HALF-1:0]};
      r_lh_p2  <= {{HALF{1'b0}}, r_a_p1[HALF-1:0]}     * {{HALF{1'b0}}, r_b_p1[WIDTH-1:HALF]};
      r_hl_p2  <= {{HALF{1'b0}}, r_a_p1[WIDTH-1:HALF]} * {{HALF{1'b0}}, r_b_p1[HALF-1:0]};
      r_hh_p2  <= {{HALF{1'b0}}, r_a_p1[WIDTH-1:HALF]} * {{HALF{1'b0}}, r_b_p1[WIDTH-1:HALF]};
      r_neg_p2 <= r_neg_p1;
    end
  end

  // S3: full-width accumulate of the aligned partial products
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum_p3 <= '0;
      r_neg_p3 <= 1'b0;
    end else if (w_stage_valid[1]) begin
      r_sum_p3 <= {{WIDTH{1'b0}}, r_ll_p2}
                + {{HALF{1'b0}}, r_lh_p2, {HALF{1'b0}}}
                + {{HALF{1'b0}}, r_hl_p2, {HALF{1'b0}}}
                + {r_hh_p2, {WIDTH{1'b0}}};
      r_neg_p3 <= r_neg_p2;
    end
  end

  // S4: sign fix-up; holds the last result between completions
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prod_p4 <= '0;
    end else if (w_stage_valid[2]) begin
      r_prod_p4 <= apply_sign(r_neg_p3, $signed(r_sum_p3));
    end
  end

  assign mul_wb_valid    = w_stage_valid[LATENCY-1];
  assign mul_wb_hi       = r_prod_p4[PW-1:WIDTH];
  assign mul_wb_lo       = r_prod_p4[WIDTH-1:0];
  assign mul_stage_valid = w_stage_valid;
  assign mul_busy        = |w_stage_valid;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: a behavioural 64-bit product model predicts each
// result at issue time; the monitor pops and compares whenever mul_wb_valid is seen.
`timescale 1ns/1ps
module tb_mul_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_mul_oper;
  logic [31:0] iss_ex_rega, iss_ex_regb;
  logic        iss_ex_unsig;
  logic [4:0]  iss_ex_regdest;
  logic        iss_ex_writereg;
  logic        mul_wb_valid;
  logic [31:0] mul_wb_hi, mul_wb_lo;
  logic [4:0]  mul_wb_regdest;
  logic        mul_wb_writereg;
  logic [3:0]  mul_stage_valid;
  logic        mul_busy;

  mul_unit dut (
    .clock           (clock),
    .reset           (reset),
    .iss_mul_oper    (iss_mul_oper),
    .iss_ex_rega     (iss_ex_rega),
    .iss_ex_regb     (iss_ex_regb),
    .iss_ex_unsig    (iss_ex_unsig),
    .iss_ex_regdest  (iss_ex_regdest),
    .iss_ex_writereg (iss_ex_writereg),
    .mul_wb_valid    (mul_wb_valid),
    .mul_wb_hi       (mul_wb_hi),
    .mul_wb_lo       (mul_wb_lo),
    .mul_wb_regdest  (mul_wb_regdest),
    .mul_wb_writereg (mul_wb_writereg),
    .mul_stage_valid (mul_stage_valid),
    .mul_busy        (mul_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] prod;
    logic [4:0]  rd;
    logic        wr;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one op for one cycle and record its predicted result and completion cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u,
                       input logic [4:0] rd, input logic wr);
    exp_t   e;
    longint sa, sb;
    @(negedge clock);
    iss_mul_oper    = 1'b1;
    iss_ex_rega     = a;
    iss_ex_regb     = b;
    iss_ex_unsig    = u;
    iss_ex_regdest  = rd;
    iss_ex_writereg = wr;
    if (u) begin
      e.prod = {32'b0, a} * {32'b0, b};
    end else begin
      sa     = longint'($signed(a));
      sb     = longint'($signed(b));
      e.prod = sa * sb;
    end
    e.rd  = rd;
    e.wr  = wr;
    e.cyc = cyc + 4;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      iss_mul_oper    = 1'b0;
      iss_ex_rega     = $urandom;
      iss_ex_regb     = $urandom;
      iss_ex_regdest  = 5'($urandom);
      iss_ex_writereg = 1'($urandom);
    end
  endtask

  exp_t m_e;
  always @(negedge clock) begin
    if (mul_wb_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        m_e = sbq.pop_front();
        chk("hi",       {32'b0, mul_wb_hi},      {32'b0, m_e.prod[63:32]});
        chk("lo",       {32'b0, mul_wb_lo},      {32'b0, m_e.prod[31:0]});
        chk("regdest",  {59'b0, mul_wb_regdest}, {59'b0, m_e.rd});
        chk("writereg", {63'b0, mul_wb_writereg}, {63'b0, m_e.wr});
        chk("latency",  64'(cyc),                64'(m_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_sv;

  initial begin
    reset           = 1'b1;
    iss_mul_oper    = 1'b0;
    iss_ex_rega     = '0;
    iss_ex_regb     = '0;
    iss_ex_unsig    = 1'b0;
    iss_ex_regdest  = '0;
    iss_ex_writereg = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_valid",    {63'b0, mul_wb_valid},   64'd0);
    chk("rst_hi",       {32'b0, mul_wb_hi},      64'd0);
    chk("rst_lo",       {32'b0, mul_wb_lo},      64'd0);
    chk("rst_regdest",  {59'b0, mul_wb_regdest}, 64'd0);
    chk("rst_writereg", {63'b0, mul_wb_writereg}, 64'd0);
    chk("rst_stage",    {60'b0, mul_stage_valid}, 64'd0);
    chk("rst_busy",     {63'b0, mul_busy},       64'd0);

    // Directed corner operands
    issue(32'd3,         32'd5,         1'b1, 5'd7,  1'b1);
    idle(6);
    issue(32'hFFFFFFFE,  32'd3,         1'b0, 5'd8,  1'b1);
    issue(32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 5'd9,  1'b0);
    issue(32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 5'd10, 1'b1);
    issue(32'h80000000,  32'h80000000,  1'b0, 5'd11, 1'b1);
    issue(32'h80000000,  32'd1,         1'b0, 5'd12, 1'b1);
    issue(32'h80000000,  32'h80000000,  1'b1, 5'd13, 1'b1);
    issue(32'h7FFFFFFF,  32'h80000000,  1'b0, 5'd14, 1'b0);
    issue(32'd0,         32'hDEADBEEF,  1'b0, 5'd31, 1'b1);
    idle(6);

    // Occupancy fill and drain with back-to-back ops tagged 1..4
    for (int i = 0; i < 4; i++) begin
      issue($urandom, $urandom, 1'($urandom), 5'(i + 1), 1'b1);
      exp_sv = 4'((1 << i) - 1);
      chk("fill_stage", {60'b0, mul_stage_valid}, {60'b0, exp_sv});
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      if (j == 0) iss_mul_oper = 1'b0;
      exp_sv = 4'hF << j;
      chk("drain_stage", {60'b0, mul_stage_valid}, {60'b0, exp_sv});
      chk("drain_busy",  {63'b0, mul_busy},        {63'b0, (exp_sv != 4'd0)});
    end

    // Random traffic with occasional gaps
    for (int k = 0; k < 60; k++) begin
      issue($urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    // Reset while two ops are in flight: neither may complete
    issue(32'd6, 32'd7, 1'b1, 5'd20, 1'b1);
    issue(32'd8, 32'd9, 1'b0, 5'd21, 1'b1);
    @(negedge clock);
    iss_mul_oper = 1'b0;
    reset        = 1'b1;
    sbq.delete();
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_stage",   {60'b0, mul_stage_valid}, 64'd0);
    chk("midrst_busy",    {63'b0, mul_busy},        64'd0);
    chk("midrst_valid",   {63'b0, mul_wb_valid},    64'd0);
    chk("midrst_hi",      {32'b0, mul_wb_hi},       64'd0);
    chk("midrst_lo",      {32'b0, mul_wb_lo},       64'd0);
    chk("midrst_regdest", {59'b0, mul_wb_regdest},  64'd0);
    idle(8);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
